// File: rtl/rr_reconfig_mgr.sv
// rtl/rr_reconfig_mgr.sv - partial-reconfiguration manager: per-region RM selection, bitstream table and ICAP sequencing
//
// Ports:
//   clock, rst_n                 rising-edge clock, asynchronous active-low reset
//   sel_valid, sel_req           load a new target RM for every region (region i in slice i)
//   tbl_we, tbl_rr, tbl_rm,
//   tbl_addr, tbl_size           bitstream table write port (size 0 = entry invalid)
//   rc_start, rc_bop,
//   rc_baddr, rc_bsize           ICAP command: one-cycle start pulse with address and word count
//   rc_done                      ICAP transfer complete (only honoured while waiting)
//   rr_isolate                   per-region output isolation
//   busy, err, err_rr, err_clr   status, sticky error with failing region, error clear
module rr_reconfig_mgr #(
  parameter int NUM_RR   = 3,
  parameter int NUM_RM   = 4,
  parameter int SEL_W    = 2,
  parameter int HDR_SIZE = 16,
  parameter int TIMEOUT  = 4096,
  localparam int RR_W    = (NUM_RR > 1) ? $clog2(NUM_RR) : 1,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    sel_valid,
  input  logic [NUM_RR*SEL_W-1:0] sel_req,
  input  logic                    tbl_we,
  input  logic [RR_W-1:0]         tbl_rr,
  input  logic [SEL_W-1:0]        tbl_rm,
  input  logic [31:0]             tbl_addr,
  input  logic [31:0]             tbl_size,
  output logic                    rc_start,
  output logic                    rc_bop,
  output logic [31:0]             rc_baddr,
  output logic [31:0]             rc_bsize,
  input  logic                    rc_done,
  output logic [NUM_RR-1:0]       rr_isolate,
  output logic                    busy,
  output logic                    err,
  output logic [RR_W-1:0]         err_rr,
  input  logic                    err_clr
);

  localparam int IDX_W = RR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_START,
    S_WAIT,
    S_COMMIT,
    S_ERROR
  } state_t;

  state_t state, state_nx;

  logic [SEL_W-1:0] cur_sel [NUM_RR];
  logic [SEL_W-1:0] tgt_sel [NUM_RR];
  logic [31:0]      tbl_addr_mem [NUM_RR][NUM_RM];
  logic [31:0]      tbl_size_mem [NUM_RR][NUM_RM];

  logic [RR_W-1:0]   last_rr;
  logic [RR_W-1:0]   sel_rr;
  logic [SEL_W-1:0]  lat_sel;
  logic [CNT_W-1:0]  wait_cnt;

  logic [NUM_RR-1:0] mismatch;
  logic              scan_hit;
  logic [RR_W-1:0]   scan_rr;
  logic [IDX_W-1:0]  scan_idx;
  logic [31:0]       ent_addr;
  logic [31:0]       ent_size;
  logic              ent_valid;
  logic              go_start;
  logic              go_error;
  logic              active;

  // Bitstream table has no reset so a reset does not lose the programmed images.
  always_ff @(posedge clock) begin
    if (tbl_we && state != S_ERROR) begin
      for (int r = 0; r < NUM_RR; r++) begin
        for (int m = 0; m < NUM_RM; m++) begin
          if (tbl_rr == RR_W'(r) && tbl_rm == SEL_W'(m)) begin
            tbl_addr_mem[r][m] <= tbl_addr;
            tbl_size_mem[r][m] <= tbl_size;
          end
        end
      end
    end
  end

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NUM_RR; i++) begin
      mismatch[i] = (cur_sel[i] != tgt_sel[i]);
    end
  end

  // Round-robin scan starting just after the last committed region.
  always_comb begin
    scan_hit = 1'b0;
    scan_rr  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_RR; k++) begin
      scan_idx = {1'b0, last_rr} + IDX_W'(k + 1);
      if (scan_idx >= IDX_W'(NUM_RR)) begin
        scan_idx = scan_idx - IDX_W'(NUM_RR);
      end
      if (!scan_hit && mismatch[scan_idx[RR_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_rr  = scan_idx[RR_W-1:0];
      end
    end
  end

  // Table entry for the selected region's target RM; an RM index beyond the
  // table reads as an invalid (size 0) entry.
  always_comb begin
    ent_addr = '0;
    ent_size = '0;
    for (int r = 0; r < NUM_RR; r++) begin
      for (int m = 0; m < NUM_RM; m++) begin
        if (sel_rr == RR_W'(r) && tgt_sel[r] == SEL_W'(m)) begin
          ent_addr = tbl_addr_mem[r][m];
          ent_size = tbl_size_mem[r][m];
        end
      end
    end
    ent_valid = (ent_size != 32'd0);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (scan_hit) state_nx = S_LOOKUP;
      S_LOOKUP: state_nx = ent_valid ? S_START : S_ERROR;
      S_START:  state_nx = S_WAIT;
      S_WAIT: begin
        if (rc_done) begin
          state_nx = S_COMMIT;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nx = S_ERROR;
        end
      end
      S_COMMIT: state_nx = S_IDLE;
      S_ERROR:  if (err_clr) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign go_start = (state == S_LOOKUP) && (state_nx == S_START);
  assign go_error = (state != S_ERROR) && (state_nx == S_ERROR);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      for (int i = 0; i < NUM_RR; i++) begin
        cur_sel[i] <= '1;
        tgt_sel[i] <= '1;
      end
      last_rr  <= RR_W'(NUM_RR - 1);
      sel_rr   <= '0;
      lat_sel  <= '1;
      wait_cnt <= '0;
      rc_start <= 1'b0;
      rc_bop   <= 1'b0;
      rc_baddr <= '0;
      rc_bsize <= '0;
      err_rr   <= '0;
    end else begin
      state <= state_nx;

      if (sel_valid && state != S_ERROR) begin
        for (int i = 0; i < NUM_RR; i++) begin
          tgt_sel[i] <= sel_req[i*SEL_W +: SEL_W];
        end
      end

      if (state == S_IDLE && scan_hit) begin
        sel_rr <= scan_rr;
      end

      // Start/bop are registered off the LOOKUP->START transition so they are
      // high for exactly the START cycle.
      rc_start <= go_start;
      rc_bop   <= go_start;
      if (go_start) begin
        rc_baddr         <= ent_addr;
        rc_bsize         <= ent_size + 32'(HDR_SIZE);
        lat_sel          <= tgt_sel[sel_rr];
        cur_sel[sel_rr]  <= '1;
      end

      wait_cnt <= (state == S_WAIT && state_nx == S_WAIT) ? wait_cnt + 1'b1 : '0;

      // Commit the RM that was actually loaded, not whatever tgt_sel holds now;
      // a newer request is then picked up again from IDLE.
      if (state == S_COMMIT) begin
        cur_sel[sel_rr] <= lat_sel;
        last_rr         <= sel_rr;
      end

      if (go_error) begin
        err_rr          <= sel_rr;
        cur_sel[sel_rr] <= '1;
      end
    end
  end

  assign active = (state == S_LOOKUP) || (state == S_START) ||
                  (state == S_WAIT)   || (state == S_COMMIT);

  always_comb begin
    rr_isolate = '0;
    for (int i = 0; i < NUM_RR; i++) begin
      rr_isolate[i] = (cur_sel[i] == '1) || (active && sel_rr == RR_W'(i));
    end
  end

  // Pending mismatches count as busy so back-to-back regions keep busy high
  // through the single IDLE cycle between commits.
  assign busy = (state != S_IDLE) || (|mismatch);
  assign err  = (state == S_ERROR);

endmodule

// File: tb/tb_rr_reconfig_mgr.sv
// tb/tb_rr_reconfig_mgr.sv - directed self-checking bench for rr_reconfig_mgr
module tb_rr_reconfig_mgr;

  localparam int TIMEOUT = 4096;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_valid = 1'b0;
  logic [5:0]  sel_req = 6'h3F;
  logic        tbl_we = 1'b0;
  logic [1:0]  tbl_rr = '0;
  logic [1:0]  tbl_rm = '0;
  logic [31:0] tbl_addr = '0;
  logic [31:0] tbl_size = '0;
  logic        rc_start;
  logic        rc_bop;
  logic [31:0] rc_baddr;
  logic [31:0] rc_bsize;
  logic        rc_done = 1'b0;
  logic [2:0]  rr_isolate;
  logic        busy;
  logic        err;
  logic [1:0]  err_rr;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  rr_reconfig_mgr #(
    .NUM_RR(3), .NUM_RM(4), .SEL_W(2), .HDR_SIZE(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .sel_valid(sel_valid), .sel_req(sel_req),
    .tbl_we(tbl_we), .tbl_rr(tbl_rr), .tbl_rm(tbl_rm),
    .tbl_addr(tbl_addr), .tbl_size(tbl_size),
    .rc_start(rc_start), .rc_bop(rc_bop), .rc_baddr(rc_baddr), .rc_bsize(rc_bsize),
    .rc_done(rc_done), .rr_isolate(rr_isolate),
    .busy(busy), .err(err), .err_rr(err_rr), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sel_valid;
    logic [5:0]  sel_req;
    logic        rc_done;
    logic        rc_start;
    logic [31:0] baddr;
    logic [31:0] bsize;
    logic [2:0]  iso;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    sel_valid = 1'b0;
    sel_req = 6'h3F;
    rc_done = 1'b0;
    err_clr = 1'b0;
    tbl_we = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wr(input logic [1:0] rr, input logic [1:0] rm, input logic [31:0] a, input logic [31:0] s);
    tbl_we = 1'b1;
    tbl_rr = rr;
    tbl_rm = rm;
    tbl_addr = a;
    tbl_size = s;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic request(input logic [5:0] req);
    sel_valid = 1'b1;
    sel_req = req;
    step();
    sel_valid = 1'b0;
  endtask

  // Steps until rc_start is seen, giving up after limit cycles.
  task automatic wait_start(input string name, input int limit, input logic chk_busy);
    for (int n = 0; n < limit; n++) begin
      step();
      if (chk_busy) chk({name, "_busy"}, busy, 1);
      if (rc_start) break;
    end
    chk({name, "_start_seen"}, rc_start, 1);
  endtask

  // Called in the START cycle; ends in the cycle after COMMIT.
  task automatic finish_xfer(input string name, input int delay, input logic chk_busy);
    step();
    for (int n = 0; n < delay; n++) begin
      step();
      if (chk_busy) chk({name, "_wait_busy"}, busy, 1);
    end
    rc_done = 1'b1;
    step();
    if (chk_busy) chk({name, "_commit_busy"}, busy, 1);
    rc_done = 1'b0;
    step();
  endtask

  initial begin
    logic saw_start;

    // Single-transfer vectors: inputs then expected outputs after the edge.
    vecs[0] = '{1'b1, 6'h3D, 1'b0, 1'b0, 32'h0,  32'h0,  3'b111, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 6'h3D, 1'b0, 1'b0, 32'h0,  32'h0,  3'b111, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 6'h3D, 1'b0, 1'b1, 32'h20, 32'h20, 3'b111, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 6'h3D, 1'b0, 1'b0, 32'h20, 32'h20, 3'b111, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 6'h3D, 1'b1, 1'b0, 32'h20, 32'h20, 3'b111, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 6'h3D, 1'b0, 1'b0, 32'h20, 32'h20, 3'b110, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 6'h3D, 1'b1, 1'b0, 32'h20, 32'h20, 3'b110, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 6'h3D, 1'b0, 1'b0, 32'h20, 32'h20, 3'b110, 1'b0, 1'b0};

    reset_dut();
    chk("rst_rc_start", rc_start, 0);
    chk("rst_rc_bop", rc_bop, 0);
    chk("rst_baddr", rc_baddr, 0);
    chk("rst_bsize", rc_bsize, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_rr", err_rr, 0);
    chk("rst_iso", rr_isolate, 3'b111);

    wr(2'd0, 2'd1, 32'h20,  32'd16);
    wr(2'd0, 2'd2, 32'h40,  32'd8);
    wr(2'd1, 2'd0, 32'h100, 32'h10);
    wr(2'd1, 2'd1, 32'h180, 32'd0);
    wr(2'd2, 2'd0, 32'h200, 32'd4);

    for (int i = 0; i < 8; i++) begin
      sel_valid = vecs[i].sel_valid;
      sel_req   = vecs[i].sel_req;
      rc_done   = vecs[i].rc_done;
      step();
      chk($sformatf("vec%0d_rc_start", i), rc_start, vecs[i].rc_start);
      chk($sformatf("vec%0d_baddr", i), rc_baddr, vecs[i].baddr);
      chk($sformatf("vec%0d_bsize", i), rc_bsize, vecs[i].bsize);
      chk($sformatf("vec%0d_iso", i), rr_isolate, vecs[i].iso);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
    end
    sel_valid = 1'b0;
    rc_done = 1'b0;

    // All three regions mismatched from reset: RR0, RR1, RR2 in order.
    reset_dut();
    request(6'h02);
    chk("rr3_busy_load", busy, 1);
    wait_start("rr3_a", 10, 1'b1);
    chk("rr3_a_baddr", rc_baddr, 32'h40);
    chk("rr3_a_bsize", rc_bsize, 32'd24);
    chk("rr3_a_iso", rr_isolate, 3'b111);
    finish_xfer("rr3_a", 2, 1'b1);
    chk("rr3_a_iso_after", rr_isolate, 3'b110);
    chk("rr3_a_busy_after", busy, 1);
    wait_start("rr3_b", 10, 1'b1);
    chk("rr3_b_baddr", rc_baddr, 32'h100);
    chk("rr3_b_bsize", rc_bsize, 32'h20);
    chk("rr3_b_iso", rr_isolate, 3'b110);
    finish_xfer("rr3_b", 2, 1'b1);
    chk("rr3_b_iso_after", rr_isolate, 3'b100);
    chk("rr3_b_busy_after", busy, 1);
    wait_start("rr3_c", 10, 1'b1);
    chk("rr3_c_baddr", rc_baddr, 32'h200);
    chk("rr3_c_bsize", rc_bsize, 32'd20);
    chk("rr3_c_iso", rr_isolate, 3'b100);
    finish_xfer("rr3_c", 2, 1'b1);
    chk("rr3_c_iso_after", rr_isolate, 3'b000);
    chk("rr3_c_busy_after", busy, 0);

    // Invalid (size 0) entry for RR1/RM1.
    reset_dut();
    request(6'h37);
    saw_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (rc_start) saw_start = 1'b1;
      if (err) break;
    end
    chk("inv_no_start", saw_start, 0);
    chk("inv_err", err, 1);
    chk("inv_err_rr", err_rr, 2'd1);
    chk("inv_busy", busy, 1);
    chk("inv_iso1", rr_isolate[1], 1);
    rc_done = 1'b1;
    sel_valid = 1'b1;
    sel_req = 6'h3F;
    step();
    chk("inv_err_hold", err, 1);
    rc_done = 1'b0;
    sel_valid = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("inv_err_cleared", err, 0);
    chk("inv_clr_no_start", rc_start, 0);
    step();
    step();
    chk("inv_retrigger_err", err, 1);
    chk("inv_retrigger_err_rr", err_rr, 2'd1);

    // rc_done withheld: error after exactly TIMEOUT wait cycles.
    reset_dut();
    request(6'h0F);
    wait_start("to", 10, 1'b0);
    chk("to_baddr", rc_baddr, 32'h200);
    for (int n = 0; n < TIMEOUT; n++) step();
    chk("to_err_before", err, 0);
    step();
    chk("to_err_at", err, 1);
    chk("to_err_rr", err_rr, 2'd2);
    chk("to_iso2", rr_isolate[2], 1);
    rc_done = 1'b1;
    step();
    rc_done = 1'b0;
    chk("to_late_done_err", err, 1);
    chk("to_late_done_iso2", rr_isolate[2], 1);
    chk("to_late_done_busy", busy, 1);

    // Target changes mid-WAIT: first transfer completes, then RM2 is loaded.
    reset_dut();
    request(6'h3D);
    wait_start("chg", 10, 1'b0);
    chk("chg_a_baddr", rc_baddr, 32'h20);
    chk("chg_a_bop", rc_bop, 1);
    step();
    sel_valid = 1'b1;
    sel_req = 6'h3E;
    step();
    sel_valid = 1'b0;
    rc_done = 1'b1;
    step();
    rc_done = 1'b0;
    step();
    chk("chg_mid_iso", rr_isolate, 3'b110);
    chk("chg_mid_busy", busy, 1);
    wait_start("chg_b", 10, 1'b0);
    chk("chg_b_baddr", rc_baddr, 32'h40);
    chk("chg_b_bsize", rc_bsize, 32'd24);
    finish_xfer("chg_b", 1, 1'b0);
    chk("chg_b_iso_after", rr_isolate, 3'b110);
    chk("chg_b_busy_after", busy, 0);

    // Asynchronous reset in the middle of WAIT.
    reset_dut();
    request(6'h3D);
    wait_start("ar", 10, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("ar_rc_start", rc_start, 0);
    chk("ar_rc_bop", rc_bop, 0);
    chk("ar_baddr", rc_baddr, 0);
    chk("ar_bsize", rc_bsize, 0);
    chk("ar_busy", busy, 0);
    chk("ar_err", err, 0);
    chk("ar_iso", rr_isolate, 3'b111);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_idle_busy", busy, 0);
    request(6'h3D);
    wait_start("ar_re", 10, 1'b0);
    chk("ar_re_baddr", rc_baddr, 32'h20);
    chk("ar_re_bsize", rc_bsize, 32'h20);
    finish_xfer("ar_re", 0, 1'b0);
    chk("ar_re_iso_after", rr_isolate, 3'b110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
